// File: rtl/dcache_flush_walker_pkg.sv
// dcache_flush_walker_pkg: cache geometry constants and the flush walker state encoding shared with the controller.
package dcache_flush_walker_pkg;
  localparam int DC_INDEX_W  = 8;
  localparam int DC_TAG_W    = 20;
  localparam int DC_OFFSET_W = 4;
  localparam logic [2:0] FL_IDLE  = 3'd0;
  localparam logic [2:0] FL_SCAN  = 3'd1;
  localparam logic [2:0] FL_ISSUE = 3'd2;
  localparam logic [2:0] FL_WAIT  = 3'd3;
  localparam logic [2:0] FL_CLEAR = 3'd4;
  localparam logic [2:0] FL_DONE  = 3'd5;
  typedef enum logic [2:0] {
    S_IDLE  = FL_IDLE,
    S_SCAN  = FL_SCAN,
    S_ISSUE = FL_ISSUE,
    S_WAIT  = FL_WAIT,
    S_CLEAR = FL_CLEAR,
    S_DONE  = FL_DONE
  } flush_state_e;
endpackage

// File: rtl/dcache_flush_walker.sv
// dcache_flush_walker: walks every dirty bit on flush, writes back dirty lines one at a time and clears their bits.
module dcache_flush_walker
  import dcache_flush_walker_pkg::*;
#(
  parameter int INDEX_W  = DC_INDEX_W,
  parameter int TAG_W    = DC_TAG_W,
  parameter int OFFSET_W = DC_OFFSET_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  output logic [INDEX_W-1:0] dir_addr,
  input  logic               dir_dout,
  output logic               dir_en,
  output logic               dir_din,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               wb_valid,
  output logic [31:0]        wb_addr,
  input  logic               wb_ready,
  input  logic               wb_done
);
  localparam logic [INDEX_W-1:0] LAST = '1;
  flush_state_e       state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [31:0]        wb_addr_q, wb_addr_d;
  logic               last;
  assign last = idx_q == LAST;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wb_addr_q <= wb_addr_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wb_addr_d = wb_addr_q;
    case (state_q)
      S_IDLE: if (flush_req) begin
        state_d = S_SCAN;
        idx_d   = '0;
      end
      S_SCAN: if (dir_dout) begin
        wb_addr_d = {tag_in, idx_q, {OFFSET_W{1'b0}}};
        state_d   = S_ISSUE;
      end else if (last) state_d = S_DONE;
      else idx_d = idx_q + 1'b1;
      S_ISSUE: state_d = wb_ready ? S_WAIT : S_ISSUE;
      S_WAIT:  state_d = wb_done ? S_CLEAR : S_WAIT;
      S_CLEAR: begin
        state_d = last ? S_DONE : S_SCAN;
        idx_d   = last ? idx_q : idx_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign flush_busy = state_q != S_IDLE;
  assign flush_done = state_q == S_DONE;
  assign dir_addr   = state_q == S_IDLE ? '0 : idx_q;
  assign dir_en     = state_q == S_CLEAR;
  assign dir_din    = 1'b0;
  assign wb_valid   = state_q == S_ISSUE;
  assign wb_addr    = wb_addr_q;
endmodule

// File: tb/tb_dcache_flush_walker.sv
// tb_dcache_flush_walker: randomized scoreboard bench with a dirty/tag array model and a writeback responder.
module tb_dcache_flush_walker;
  localparam int LINES = 256;
  logic        clk = 0, reset = 1, flush_req = 0;
  logic        flush_busy, flush_done, dir_en, dir_din, wb_valid, wb_ready, wb_done;
  logic [7:0]  dir_addr;
  logic        dir_dout;
  logic [19:0] tag_in;
  logic [31:0] wb_addr;
  logic        dirty [LINES];
  logic [19:0] tags [LINES];
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, extra = 0, done_cnt = 0, acc_cnt = 0;
  int min_stall = 0, max_stall = 0, max_delay = 1;
  bit hold = 0, first_chk = 0, pend = 0;
  logic [31:0] prev_addr;
  logic [31:0] wb_q[$];
  int          clr_q[$];
  dcache_flush_walker dut (
    .clk(clk), .reset(reset), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .dir_addr(dir_addr), .dir_dout(dir_dout), .dir_en(dir_en),
    .dir_din(dir_din), .tag_in(tag_in), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_ready(wb_ready), .wb_done(wb_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign dir_dout = dirty[dir_addr];
  assign tag_in   = tags[dir_addr];
  always @(posedge clk) if (dir_en) dirty[dir_addr] <= dir_din;
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) if (!reset) begin
    if (first_chk) begin
      chk("scan_start", {flush_busy, dir_addr}, {1'b1, 8'd0});
      first_chk = 0;
    end
    if (flush_req && !flush_busy) begin
      start_cyc = cyc;
      first_chk = 1;
    end
    if (pend) chk("wb_hold", {wb_valid, wb_addr}, {1'b1, prev_addr});
    pend = 0;
    if (wb_valid) begin
      if (wb_ready) begin
        acc_cnt++;
        if (wb_q.size() == 0) chk("wb_extra", 1, 0);
        else chk("wb_addr", wb_addr, wb_q.pop_front());
      end else pend = 1;
      prev_addr = wb_addr;
    end
    chk("excl", {wb_valid, dir_en} == 2'b11, 0);
    if (dir_en) begin
      if (clr_q.size() == 0) chk("clr_extra", 1, 0);
      else chk("clr_idx", {dir_din, dir_addr}, {1'b0, 8'(clr_q.pop_front())});
    end
    if (flush_done) begin
      done_cnt++;
      chk("done_lat", cyc - start_cyc, LINES + 1 + extra);
      chk("wb_left", wb_q.size(), 0);
      chk("clr_left", clr_q.size(), 0);
    end
  end
  initial begin
    int s, d;
    wb_ready = 0;
    wb_done  = 0;
    forever begin
      step();
      if (reset || !wb_valid) continue;
      s = $urandom_range(min_stall, max_stall);
      d = $urandom_range(1, max_delay);
      if (s > 0) begin
        wb_done = 1;
        step();
        wb_done = 0;
        repeat (s - 1) step();
      end
      wb_ready = 1;
      step();
      wb_ready = 0;
      for (int k = 1; k < d || hold; k++) begin
        if (reset) break;
        step();
      end
      if (reset) continue;
      wb_done = 1;
      extra += s + d + 2;
      step();
      wb_done = 0;
    end
  end
  task automatic run_flush(input bit spurious);
    int d0;
    d0 = done_cnt;
    extra = 0;
    for (int i = 0; i < LINES; i++)
      if (dirty[i]) begin
        wb_q.push_back({tags[i], 8'(i), 4'h0});
        clr_q.push_back(i);
      end
    flush_req = 1;
    step();
    flush_req = 0;
    if (spurious) begin
      repeat (20) step();
      flush_req = 1;
      wb_done   = 1;
      step();
      flush_req = 0;
      wb_done   = 0;
    end
    for (int k = 0; k < 20000 && done_cnt == d0; k++) step();
    if (done_cnt == d0) chk("timeout", 0, 1);
    repeat (3) step();
    chk("done_once", done_cnt - d0, 1);
  endtask
  task automatic fill(input int pct);
    for (int i = 0; i < LINES; i++) begin
      dirty[i] = $urandom_range(0, 99) < pct;
      tags[i]  = 20'($urandom);
    end
  endtask
  initial begin
    int a0, left;
    fill(0);
    #12;
    chk("rst_hold", {flush_busy, flush_done, dir_addr, dir_en, wb_valid, wb_addr}, 0);
    step();
    reset = 0;
    step();
    chk("rst_out", {flush_busy, flush_done, dir_addr, dir_en, wb_valid, wb_addr}, 0);
    run_flush(1);
    dirty[5] = 1;
    tags[5]  = 20'hABCDE;
    max_delay = 3;
    min_stall = 0;
    max_stall = 0;
    wb_q.push_back(32'hABCDE050);
    void'(wb_q.pop_back());
    run_flush(0);
    chk("line5_clear", dirty[5], 0);
    dirty[0]   = 1;
    dirty[255] = 1;
    min_stall  = 4;
    max_stall  = 4;
    max_delay  = 2;
    run_flush(0);
    chk("ends_clear", {dirty[0], dirty[255]}, 0);
    min_stall = 0;
    max_stall = 3;
    max_delay = 4;
    repeat (3) begin
      fill(15);
      run_flush(0);
    end
    fill(0);
    dirty[17] = 1;
    dirty[40] = 1;
    min_stall = 0;
    max_stall = 0;
    hold = 1;
    a0 = acc_cnt;
    for (int i = 0; i < LINES; i++)
      if (dirty[i]) begin
        wb_q.push_back({tags[i], 8'(i), 4'h0});
        clr_q.push_back(i);
      end
    flush_req = 1;
    step();
    flush_req = 0;
    for (int k = 0; k < 2000 && acc_cnt == a0; k++) step();
    chk("wait_reached", acc_cnt - a0, 1);
    repeat (3) step();
    @(negedge clk);
    #2 reset = 1;
    #1 chk("rst_async", {flush_busy, flush_done, dir_addr, dir_en, wb_valid, wb_addr}, 0);
    hold = 0;
    pend = 0;
    first_chk = 0;
    wb_q.delete();
    clr_q.delete();
    step();
    reset = 0;
    step();
    chk("dirty17_kept", dirty[17], 1);
    run_flush(0);
    chk("dirty17_done", {dirty[17], dirty[40]}, 0);
    fill(100);
    max_stall = 0;
    max_delay = 1;
    run_flush(0);
    left = 0;
    for (int i = 0; i < LINES; i++) left += int'(dirty[i]);
    chk("all_clean", left, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
